// File: rtl/mux3_response_checker_if.sv
// Handshake and result bundle between the mux stimulus side and the checker.
interface mux3_response_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             vec_valid;
    logic             A;
    logic             B;
    logic             C;
    logic             OUT;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [7:0]       cov_mask;
    logic             fail_valid;
    logic [2:0]       fail_vec;
    logic             fail_out;

    modport master (
        output start, vec_valid, A, B, C, OUT,
        input  busy, done, pass, err_count, cov_mask,
        input  fail_valid, fail_vec, fail_out
    );

    modport slave (
        input  start, vec_valid, A, B, C, OUT,
        output busy, done, pass, err_count, cov_mask,
        output fail_valid, fail_vec, fail_out
    );
endinterface

// File: rtl/mux3_response_checker.sv
// Response checker for the 3-input mux: settles, samples OUT, compares
// against TRUTH and accumulates error count, coverage and first failure.
module mux3_response_checker #(
    parameter logic [7:0]  TRUTH  = 8'hCA,
    parameter int unsigned SETTLE = 2,
    parameter int          CNT_W  = 8
) (
    input logic                    clk,
    input logic                    rst,
    mux3_response_checker_if.slave bus
);
    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [2:0]       vec_q, vec_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [7:0]       cov_q, cov_d;
    logic             fv_q, fv_d;
    logic [2:0]       fvec_q, fvec_d;
    logic             fout_q, fout_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        err_d   = err_q;
        cov_d   = cov_q;
        fv_d    = fv_q;
        fvec_d  = fvec_q;
        fout_d  = fout_q;
        done_d  = done_q;
        pass_d  = pass_q;
        if (bus.start) begin
            state_d = S_ARMED;
            err_d   = '0;
            cov_d   = '0;
            fv_d    = 1'b0;
            fvec_d  = '0;
            fout_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_ARMED: begin
                    if (bus.vec_valid) begin
                        vec_d   = {bus.A, bus.B, bus.C};
                        cnt_d   = SETTLE_L;
                        state_d = (SETTLE_L == 4'd0) ? S_CHECK : S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) state_d = S_CHECK;
                end
                S_CHECK: begin
                    if (bus.OUT != TRUTH[vec_q]) begin
                        if (err_q != '1) err_d = err_q + 1'b1;
                        if (!fv_q) begin
                            fv_d   = 1'b1;
                            fvec_d = vec_q;
                            fout_d = bus.OUT;
                        end
                    end
                    cov_d = cov_q | (8'b1 << vec_q);
                    if (cov_d == 8'hFF) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        state_d = S_ARMED;
                    end
                end
                default: ;
            endcase
        end
        // Registered busy tracks the state being entered.
        busy_d = (state_d == S_SETTLE) || (state_d == S_CHECK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            cov_q   <= '0;
            fv_q    <= 1'b0;
            fvec_q  <= '0;
            fout_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            cov_q   <= cov_d;
            fv_q    <= fv_d;
            fvec_q  <= fvec_d;
            fout_q  <= fout_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_count  = err_q;
    assign bus.cov_mask   = cov_q;
    assign bus.fail_valid = fv_q;
    assign bus.fail_vec   = fvec_q;
    assign bus.fail_out   = fout_q;
endmodule

// File: tb/tb_mux3_response_checker.sv
// Scoreboard bench for mux3_response_checker: default instance plus a
// 2-bit counter instance fed the same vectors with an inverted response.
module tb_mux3_response_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux3_response_checker_if #(.CNT_W(8)) vif ();
    mux3_response_checker_if #(.CNT_W(2)) sif ();

    mux3_response_checker #(.CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .bus(vif)
    );
    mux3_response_checker #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .bus(sif)
    );

    logic [7:0] tr = 8'hCA;

    assign sif.start     = vif.start;
    assign sif.vec_valid = vif.vec_valid;
    assign sif.A         = vif.A;
    assign sif.B         = vif.B;
    assign sif.C         = vif.C;
    assign sif.OUT       = ~tr[{vif.A, vif.B, vif.C}];

    typedef struct packed {
        logic [2:0] v;
        logic       o;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] m_err;
    logic [7:0] m_cov;
    logic       m_fv;
    logic [2:0] m_fvec;
    logic       m_fout;

    function automatic logic mux(input logic [2:0] v);
        return v[2] ? v[1] : v[0];
    endfunction

    function automatic void model(input exp_t e);
        if (e.o !== tr[e.v]) begin
            if (m_err != 8'hFF) m_err = m_err + 8'd1;
            if (!m_fv) begin
                m_fv   = 1'b1;
                m_fvec = e.v;
                m_fout = e.o;
            end
        end
        m_cov = m_cov | (8'b1 << e.v);
    endfunction

    task automatic do_start();
        @(negedge clk);
        vif.start = 1'b1;
        @(negedge clk);
        vif.start = 1'b0;
        m_err = '0; m_cov = '0; m_fv = 0; m_fvec = '0; m_fout = 0;
        sb.delete();
    endtask

    // Called at a negedge; returns at the negedge after the check edge.
    task automatic apply(input logic [2:0] v, input logic o);
        {vif.A, vif.B, vif.C} = v;
        vif.OUT       = o;
        vif.vec_valid = 1'b1;
        sb.push_back({v, o});
        @(negedge clk);
        vif.vec_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({vif.busy, vif.done, vif.pass, vif.fail_valid} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 0000",
                     {vif.busy, vif.done, vif.pass, vif.fail_valid});
        end
        n_cmp++;
        if ({vif.err_count, vif.cov_mask, vif.fail_vec, vif.fail_out} !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_regs: got %h want 0",
                     {vif.err_count, vif.cov_mask, vif.fail_vec, vif.fail_out});
        end
    endtask

    task automatic test_all_pass();
        exp_t e;
        do_start();
        for (int i = 0; i < 8; i++) begin
            apply(3'(i), mux(3'(i)));
            e = sb.pop_front();
            model(e);
            n_cmp++;
            if (vif.cov_mask !== m_cov || vif.err_count !== m_err) begin
                n_bad++;
                $display("FAIL pass_step%0d: got cov %h err %0d want cov %h err %0d",
                         i, vif.cov_mask, vif.err_count, m_cov, m_err);
            end
        end
        n_cmp++;
        if ({vif.done, vif.pass, vif.fail_valid, vif.busy} !== 4'b1100) begin
            n_bad++;
            $display("FAIL pass_final: got done/pass/fv/busy %b want 1100",
                     {vif.done, vif.pass, vif.fail_valid, vif.busy});
        end
        n_cmp++;
        if (vif.cov_mask !== 8'hFF || vif.err_count !== 8'd0) begin
            n_bad++;
            $display("FAIL pass_cov: got cov %h err %0d want ff 0",
                     vif.cov_mask, vif.err_count);
        end
    endtask

    task automatic test_saturate();
        n_cmp++;
        if (sif.err_count !== 2'd3) begin
            n_bad++;
            $display("FAIL sat_err: got %0d want 3", sif.err_count);
        end
        n_cmp++;
        if ({sif.done, sif.pass, sif.fail_valid} !== 3'b101) begin
            n_bad++;
            $display("FAIL sat_flags: got %b want 101",
                     {sif.done, sif.pass, sif.fail_valid});
        end
        n_cmp++;
        if (sif.fail_vec !== 3'd0 || sif.fail_out !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_first: got vec %0d out %b want 0 1",
                     sif.fail_vec, sif.fail_out);
        end
    endtask

    task automatic test_forced0();
        exp_t e;
        do_start();
        for (int i = 0; i < 8; i++) begin
            apply(3'(i), 1'b0);
            e = sb.pop_front();
            model(e);
            n_cmp++;
            if (vif.err_count !== m_err || vif.fail_valid !== m_fv) begin
                n_bad++;
                $display("FAIL f0_step%0d: got err %0d fv %b want %0d %b",
                         i, vif.err_count, vif.fail_valid, m_err, m_fv);
            end
        end
        n_cmp++;
        if (vif.err_count !== 8'd4) begin
            n_bad++;
            $display("FAIL f0_err: got %0d want 4", vif.err_count);
        end
        n_cmp++;
        if (vif.fail_vec !== 3'b001 || vif.fail_out !== 1'b0) begin
            n_bad++;
            $display("FAIL f0_first: got vec %b out %b want 001 0",
                     vif.fail_vec, vif.fail_out);
        end
        n_cmp++;
        if ({vif.done, vif.pass} !== 2'b10) begin
            n_bad++;
            $display("FAIL f0_flags: got %b want 10", {vif.done, vif.pass});
        end
    endtask

    task automatic test_repeat();
        exp_t e;
        logic [2:0] seq [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd3};
        do_start();
        for (int i = 0; i < 8; i++) begin
            apply(seq[i], mux(seq[i]));
            e = sb.pop_front();
            model(e);
        end
        n_cmp++;
        if (vif.cov_mask !== 8'h7F || vif.cov_mask !== m_cov) begin
            n_bad++;
            $display("FAIL rep_cov: got %h want 7f", vif.cov_mask);
        end
        n_cmp++;
        if ({vif.done, vif.busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL rep_armed: got done/busy %b want 00",
                     {vif.done, vif.busy});
        end
        apply(3'd7, mux(3'd7));
        e = sb.pop_front();
        model(e);
        n_cmp++;
        if ({vif.done, vif.pass} !== 2'b11 || vif.cov_mask !== m_cov) begin
            n_bad++;
            $display("FAIL rep_done: got %b cov %h want 11 %h",
                     {vif.done, vif.pass}, vif.cov_mask, m_cov);
        end
    endtask

    task automatic test_held_valid();
        exp_t e;
        do_start();
        vif.OUT       = 1'b0;
        vif.vec_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            {vif.A, vif.B, vif.C} = 3'(i);
            if (i % 4 == 0) sb.push_back({3'(i), 1'b0});
            @(negedge clk);
            if (i == 0) begin
                n_cmp++;
                if (vif.busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL held_busy: got %b want 1", vif.busy);
                end
            end
        end
        vif.vec_valid = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            model(e);
        end
        n_cmp++;
        if (vif.cov_mask !== 8'h11 || vif.cov_mask !== m_cov) begin
            n_bad++;
            $display("FAIL held_cov: got %h want 11", vif.cov_mask);
        end
        n_cmp++;
        if (vif.err_count !== 8'd0 || vif.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL held_err: got err %0d busy %b want 0 0",
                     vif.err_count, vif.busy);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        do_start();
        {vif.A, vif.B, vif.C} = 3'd2;
        vif.OUT       = 1'b1;
        vif.vec_valid = 1'b1;
        @(negedge clk);
        vif.vec_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        n_cmp++;
        if ({vif.busy, vif.done, vif.pass, vif.fail_valid,
             vif.err_count, vif.cov_mask} !== 20'h0) begin
            n_bad++;
            $display("FAIL rstmid_out: got busy %b cov %h err %0d want 0",
                     vif.busy, vif.cov_mask, vif.err_count);
        end
        {vif.A, vif.B, vif.C} = 3'd5;
        vif.vec_valid = 1'b1;
        @(negedge clk);
        vif.vec_valid = 1'b0;
        n_cmp++;
        if (vif.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_busy: got %b want 0", vif.busy);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (vif.cov_mask !== 8'h00 || vif.err_count !== 8'd0) begin
            n_bad++;
            $display("FAIL idle_ignore: got cov %h err %0d want 0 0",
                     vif.cov_mask, vif.err_count);
        end
        do_start();
        for (int i = 7; i >= 0; i--) begin
            apply(3'(i), mux(3'(i)));
            e = sb.pop_front();
            model(e);
        end
        n_cmp++;
        if ({vif.done, vif.pass} !== 2'b11 || vif.cov_mask !== m_cov) begin
            n_bad++;
            $display("FAIL rstmid_pass: got %b cov %h want 11 %h",
                     {vif.done, vif.pass}, vif.cov_mask, m_cov);
        end
    endtask

    initial begin
        vif.start     = 1'b0;
        vif.vec_valid = 1'b0;
        vif.A         = 1'b0;
        vif.B         = 1'b0;
        vif.C         = 1'b0;
        vif.OUT       = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_all_pass();
        test_saturate();
        test_forced0();
        test_repeat();
        test_held_valid();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
